// File: rtl/uart_rx_frame.sv
// UART frame receiver: 8 data bits LSB first, optional odd/even parity, one stop bit.
// The received byte is held in a single-entry buffer with sticky error flags that a read acknowledge clears.
module uart_rx_frame #(
    parameter logic [15:0] BAUD_DIV = 16'h28B0,
    parameter logic [15:0] HALF_DIV = BAUD_DIV / 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rxd,
    input  logic        i_parity_en,
    input  logic        i_parity_kind,
    input  logic        i_rd_ack,
    output logic [15:0] o_rdr,
    output logic        o_rdy,
    output logic        o_parity_err,
    output logic        o_frame_err,
    output logic        o_overrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_rxd_d;
    logic [2:0]  r_state;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_en;
    logic        r_par_kind;
    logic        r_par_bit;
    logic [7:0]  r_rdr;
    logic        r_rdy;
    logic        r_parity_err;
    logic        r_frame_err;
    logic        r_overrun;

    logic w_rxd_s;
    logic w_fall;
    logic w_tick;
    logic w_stop_evt;
    logic w_stop_ok;
    logic w_accept;
    logic w_overrun_set;
    logic w_frame_set;
    logic w_par_fail;

    assign w_rxd_s       = r_sync2;
    assign w_fall        = r_rxd_d & ~w_rxd_s;
    assign w_tick        = (r_timer == 16'd1);
    assign w_stop_evt    = (r_state == S_STOP) && w_tick;
    assign w_stop_ok     = w_stop_evt && w_rxd_s;
    assign w_accept      = w_stop_ok && (!r_rdy || i_rd_ack);
    assign w_overrun_set = w_stop_ok && r_rdy && !i_rd_ack;
    assign w_frame_set   = w_stop_evt && !w_rxd_s;
    assign w_par_fail    = r_par_en && ((^r_shift ^ r_par_bit) != r_par_kind);

    // Line is idle high, so the synchronizer and edge history reset to 1 to avoid a false start edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_rxd_d <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_rxd_d <= r_sync2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= 16'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_en   <= 1'b0;
            r_par_kind <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            // Timer runs in every non-idle state; transitions below override the load where needed.
            if (r_state != S_IDLE)
                r_timer <= w_tick ? BAUD_DIV : r_timer - 16'd1;
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state <= S_START;
                        r_timer <= HALF_DIV;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (!w_rxd_s) begin
                            r_state    <= S_DATA;
                            r_bit_cnt  <= 3'd0;
                            r_par_en   <= i_parity_en;
                            r_par_kind <= i_parity_kind;
                        end else begin
                            r_state <= S_IDLE;
                            r_timer <= 16'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rxd_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= r_par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (w_tick) begin
                        r_par_bit <= w_rxd_s;
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state   <= S_IDLE;
                        r_timer   <= 16'd0;
                        r_bit_cnt <= 3'd0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= 16'd0;
                end
            endcase
        end
    end

    // A read acknowledge clears everything, but a flag being set in the same cycle takes priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdr        <= 8'h00;
            r_rdy        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (i_rd_ack) begin
                r_rdy        <= 1'b0;
                r_parity_err <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
            end
            if (w_accept) begin
                r_rdr        <= r_shift;
                r_rdy        <= 1'b1;
                r_parity_err <= w_par_fail;
            end
            if (w_frame_set)
                r_frame_err <= 1'b1;
            if (w_overrun_set)
                r_overrun <= 1'b1;
        end
    end

    assign o_rdr        = {8'h00, r_rdr};
    assign o_rdy        = r_rdy;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: a frame-level model predicts the receive buffer and flags,
// compared every cycle, plus literal checks after each directed scenario.
module tb_uart_rx_frame;

    localparam int BAUD = 16;
    localparam int HALF = 8;
    // 2 synchronizer flops plus one cycle to see the falling edge
    localparam int DETECT_LAT = 3;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic        parity_en;
    logic        parity_kind;
    logic        rd_ack;
    logic [15:0] rdr;
    logic        rdy;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;

    uart_rx_frame #(.BAUD_DIV(16'd16), .HALF_DIV(16'd8)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rxd         (rxd),
        .i_parity_en   (parity_en),
        .i_parity_kind (parity_kind),
        .i_rd_ack      (rd_ack),
        .o_rdr         (rdr),
        .o_rdy         (rdy),
        .o_parity_err  (parity_err),
        .o_frame_err   (frame_err),
        .o_overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       stop;
        logic       pfail;
    } frame_ev_t;

    frame_ev_t  evq[$];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    bit         chk_en = 0;
    logic [7:0] m_rdr = 8'h00;
    logic       m_rdy = 1'b0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;

    // Model: buffer/flag behaviour at frame granularity, applied at the predicted stop-sample edge.
    initial forever begin
        frame_ev_t ev;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_rdr = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            evq.delete();
        end else begin
            bit ack;
            ack = rd_ack;
            if (ack) begin
                m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                ev = evq.pop_front();
                if (!ev.stop)
                    m_ferr = 1'b1;
                else if (!m_rdy || ack) begin
                    m_rdr = ev.data; m_rdy = 1'b1; m_perr = ev.pfail;
                end else
                    m_ovr = 1'b1;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            tests++;
            if ({rdr, rdy, parity_err, frame_err, overrun} !== {8'h00, m_rdr, m_rdy, m_perr, m_ferr, m_ovr}) begin
                fails++;
                $display("FAIL cycle_compare cyc=%0d got rdr=%h rdy=%b perr=%b ferr=%b ovr=%b expected rdr=%h rdy=%b perr=%b ferr=%b ovr=%b",
                         cyc, rdr, rdy, parity_err, frame_err, overrun,
                         {8'h00, m_rdr}, m_rdy, m_perr, m_ferr, m_ovr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1;
        rd_ack = 1'b1;
        @(posedge clk); #1;
        rd_ack = 1'b0;
    endtask

    // Drives one frame bit-by-bit; abort_t >= 0 pulses reset at that cycle offset instead of finishing.
    task automatic send_frame(input logic [7:0] data, input logic pen, input logic pkind,
                              input logic pbit, input logic stopv, input bit ack_at_stop,
                              input int abort_t);
        logic [10:0] bits;
        int nb;
        int c0;
        int stop_edge;
        frame_ev_t ev;
        nb = pen ? 10 : 9;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        if (pen) bits[9] = pbit;
        bits[nb] = stopv;
        parity_en = pen;
        parity_kind = pkind;
        @(posedge clk); #1;
        c0 = cyc;
        stop_edge = c0 + DETECT_LAT + HALF + nb * BAUD;
        ev.cyc = stop_edge;
        ev.data = data;
        ev.stop = stopv;
        ev.pfail = pen && ((^data ^ pbit) != pkind);
        evq.push_back(ev);
        for (int t = 0; t < (nb + 1) * BAUD; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
            end
            if (abort_t >= 0 && t == abort_t) begin
                rst = 1'b1;
                rxd = 1'b1;
                rd_ack = 1'b0;
                idle(2);
                rst = 1'b0;
                return;
            end
            rxd = bits[t / BAUD];
            rd_ack = ack_at_stop && (cyc + 1 == stop_edge);
        end
        rd_ack = 1'b0;
        rxd = 1'b1;
    endtask

    initial begin
        rst = 1'b1; rxd = 1'b1; parity_en = 1'b0; parity_kind = 1'b0; rd_ack = 1'b0;
        idle(3);
        chk_en = 1;
        chk("reset_rdr", {16'h0, rdr}, 32'h0);
        chk("reset_flags", {28'h0, rdy, parity_err, frame_err, overrun}, 32'h0);
        rst = 1'b0;
        idle(4);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(5);
        chk("f5A_rdr", {16'h0, rdr}, 32'h005A);
        chk("f5A_rdy", {31'h0, rdy}, 32'h1);
        chk("f5A_flags", {29'h0, parity_err, frame_err, overrun}, 32'h0);
        ack_pulse(); idle(1);
        chk("f5A_ack_rdy", {31'h0, rdy}, 32'h0);

        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 0, -1);
        idle(5);
        chk("f03_rdr", {16'h0, rdr}, 32'h0003);
        chk("f03_rdy", {31'h0, rdy}, 32'h1);
        chk("f03_perr", {31'h0, parity_err}, 32'h1);
        ack_pulse(); idle(1);
        chk("f03_ack_perr", {31'h0, parity_err}, 32'h0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1);
        idle(5);
        chk("fA5_ferr", {31'h0, frame_err}, 32'h1);
        chk("fA5_rdy", {31'h0, rdy}, 32'h0);
        chk("fA5_rdr", {16'h0, rdr}, 32'h0003);
        ack_pulse(); idle(2);

        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(3);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(5);
        chk("ovr_rdr", {16'h0, rdr}, 32'h0011);
        chk("ovr_flag", {31'h0, overrun}, 32'h1);
        ack_pulse(); idle(2);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(3);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1);
        idle(5);
        chk("ackstop_rdr", {16'h0, rdr}, 32'h0022);
        chk("ackstop_rdy", {31'h0, rdy}, 32'h1);
        chk("ackstop_ovr", {31'h0, overrun}, 32'h0);

        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(40);
        chk("false_start_rdr", {16'h0, rdr}, 32'h0022);
        chk("false_start_flags", {28'h0, rdy, parity_err, frame_err, overrun}, 32'h8);

        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 0, 85);
        idle(20);
        chk("abort_rdr", {16'h0, rdr}, 32'h0000);
        chk("abort_rdy", {31'h0, rdy}, 32'h0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        idle(5);
        chk("f7E_rdr", {16'h0, rdr}, 32'h007E);
        chk("f7E_flags", {28'h0, rdy, parity_err, frame_err, overrun}, 32'h8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter BAUD_DIV, default 16'h28B0, clk cycles per bit (9600 bps).
REQ-002 Parameter HALF_DIV, default BAUD_DIV/2, clk cycles from start-edge detect to start-bit mid-sample.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rxd  input  1  serial line; idle high; asynchronous to clk.
REQ-006 parity_en  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 parity_kind  input  1  1 = odd parity, 0 = even parity.
REQ-008 rd_ack  input  1  one-cycle pulse; consumer has read rdr.
REQ-009 rdr  output  16  received byte in [7:0]; [15:8] always 0.
REQ-010 rdy  output  1  rdr holds an unread byte.
REQ-011 parity_err  output  1  sticky; last accepted byte failed parity.
REQ-012 frame_err  output  1  sticky; a stop bit was sampled low.
REQ-013 overrun  output  1  sticky; a byte completed while rdy=1 and was discarded.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxd_s.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: on a falling edge of rxd_s -> START, bit timer loaded with HALF_DIV.
REQ-017 START: at timer expiry, rxd_s=0 -> DATA with timer BAUD_DIV; rxd_s=1 -> IDLE (false start, no flag change).
REQ-018 DATA: sample rxd_s at each BAUD_DIV expiry, LSB first, 8 samples; after the 8th -> PARITY if parity_en else STOP.
REQ-019 PARITY: one sample at BAUD_DIV expiry; error if the XOR of the 8 data bits and the parity bit is not equal to parity_kind; -> STOP.
REQ-020 STOP: one sample at BAUD_DIV expiry, then -> IDLE in the same cycle; a new start edge is accepted from the next cycle.
REQ-021 Stop sample 0: byte discarded, frame_err<=1, rdy/rdr/parity_err unchanged.
REQ-022 Stop sample 1, rdy=0 (or rd_ack in the same cycle): rdr<={8'h00,byte}, rdy<=1, parity_err<=parity failure (0 when parity_en=0); rdy asserts 1 cycle after the stop sample edge.
REQ-023 Stop sample 1, rdy=1, no rd_ack: byte discarded, overrun<=1, rdr unchanged.
REQ-024 rd_ack SHALL clear rdy, parity_err, frame_err and overrun on the next edge; if it coincides with a flag-setting event, the set wins for that flag.
REQ-025 rd_ack while rdy=0 SHALL clear the flags and have no other effect.
REQ-026 parity_en and parity_kind SHALL be sampled at the START->DATA transition and held for the frame.
REQ-027 The bit timer SHALL be 16 bits, count down to 1 and reload; no wrap beyond BAUD_DIV.

Reset
REQ-028 rst=1 SHALL force IDLE, synchronizer flops to 1, timer and bit counter to 0, rdr=16'h0000, rdy=0, parity_err=0, frame_err=0, overrun=0.
REQ-029 rst asserted mid-frame SHALL abort the frame with no flag or rdr update; reception restarts on the next falling edge after release.

Verification (BAUD_DIV=16, HALF_DIV=8)
REQ-030 Frame 0x5A, parity_en=0, stop=1 -> rdr=16'h005A, rdy=1, all error flags 0; rd_ack -> rdy=0.
REQ-031 parity_en=1, parity_kind=0, 0x03 with parity bit 1 -> rdr=16'h0003, rdy=1, parity_err=1.
REQ-032 Frame 0xA5 with stop bit 0 -> frame_err=1, rdy stays 0, rdr unchanged.
REQ-033 Two frames 0x11 then 0x22, no rd_ack -> rdr=16'h0011, overrun=1; second pair with rd_ack in the stop-sample cycle -> rdr=16'h0022, rdy=1, overrun=0.
REQ-034 rxd low for 4 cycles then high -> FSM returns to IDLE, no outputs change.
REQ-035 rst pulsed during DATA bit 4, then a clean frame 0x7E -> rdr=16'h007E, rdy=1, no flags.
